ps2_key_event_decoder: RTL
==========================

Name: ps2_key_event_decoder

Overview:
- Sits directly downstream of the PS/2 port receiver. Consumes its byte stream (dout, rx_done_tick) and assembles multi-byte set-2 scan-code sequences (E0 extended prefix, F0 break prefix, E1 pause sequence) into single key events.
- Queues events in a small FIFO for the PicoBlaze-side reader, so no event is lost while firmware is busy.
- Flags overflow and malformed sequences.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- TIMEOUT_CYCLES, 100000, idle clocks allowed inside a multi-byte sequence (1 ms at 100 MHz) before the sequence is abandoned.
- PAUSE_TAIL, 7, bytes following E1 in the pause sequence.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_done_tick  in  1  one-cycle strobe; din valid
- din  in  8  received scan-code byte
- rd_en  in  1  pop head event
- ev_valid  out  1  FIFO non-empty; head event present on ev_*
- ev_ext  out  1  head event extended (E0 or E1 sequence)
- ev_brk  out  1  head event is a release
- ev_code  out  8  head event final scan code
- ev_count  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky: event dropped because FIFO was full
- ovf_clr  in  1  clears overflow
- proto_err  out  1  one-cycle pulse on malformed sequence or timeout

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE; FIFO empty; ev_valid=0, ev_ext=0, ev_brk=0, ev_code=0, ev_count=0, overflow=0, proto_err=0; timeout and skip counters cleared. Reset mid-sequence discards any partial sequence.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP_E1. Only cycles with rx_done_tick=1 advance on bytes.
- IDLE transitions:
  - E0 -> GOT_E0.
  - F0 -> GOT_F0.
  - E1 -> SKIP_E1 with skip count = PAUSE_TAIL.
  - AA, FA, FE, EE, 00, FF -> discarded, no event, stay in IDLE.
  - Any other byte X -> push {ext=0, brk=0, X}.
- GOT_E0 transitions:
  - F0 -> GOT_E0F0.
  - X (not E0/E1) -> push {1, 0, X}, go to IDLE.
  - E0 -> proto_err, stay in GOT_E0.
- GOT_F0 transitions:
  - X -> push {0, 1, X}, go to IDLE.
  - E0 -> proto_err, go to GOT_E0.
  - F0 -> proto_err, stay in GOT_F0.
- GOT_E0F0 transitions:
  - X -> push {1, 1, X}, go to IDLE.
  - E0 or F0 -> proto_err, go to IDLE.
- SKIP_E1: decrement on each byte; on the final byte push {1, 0, E1} and go to IDLE. No break event is generated for pause.
- Timeout: in any state other than IDLE, the counter increments every clock and resets on rx_done_tick. On reaching TIMEOUT_CYCLES-1: go to IDLE, pulse proto_err, push nothing.
- Latency: the push occurs on the edge sampling rx_done_tick with the final byte. When the FIFO was empty, ev_valid=1 and ev_* show that event the following cycle.
- FIFO is first-word fall-through:
  - ev_* is driven from the head entry and is don't-care when ev_valid=0.
  - rd_en with ev_valid=1 pops on the clock edge.
  - rd_en while empty is ignored; ev_count does not underflow.
- Push to a full FIFO with no simultaneous pop: the event is dropped and overflow is set. Contents are unchanged.
- Push and pop in the same cycle when full: both complete, ev_count unchanged, no overflow.
- Push and pop in the same cycle when empty: the push is stored and the pop is ignored.
- Pointers wrap modulo DEPTH. ev_count = write count minus read count.
- ovf_clr=1 clears overflow. If a drop occurs in the same cycle, the set wins and overflow=1.

Decomposition:
- Package ps2_kbd_pkg holds:
  - byte constants PS2_E0, PS2_F0, PS2_E1, PS2_BAT_OK(AA), PS2_ACK(FA), PS2_RESEND(FE), PS2_ECHO(EE), PS2_ERR0(00), PS2_ERR1(FF);
  - the FSM state enum;
  - a 10-bit event typedef {ext, brk, code}.
- Sub-module ps2_event_fifo: synchronous FWFT FIFO of 10-bit words, parameterised on DEPTH, with full, empty and count outputs.
- The FSM and timeout logic stay in the top level.

Test Plan:
- Bytes 1C, F0 1C with no reads -> ev_count=2; pops give {0,0,1C} then {0,1,1C}; ev_valid=0 afterwards.
- Bytes E0 75, E0 F0 75 -> events {1,0,75} then {1,1,75}; proto_err stays 0.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {1,0,E1}; a following 1C yields {0,0,1C}.
- E0 then 100000 idle cycles, then 1C -> proto_err pulses once at the timeout; only event is {0,0,1C}.
- Nine single-byte codes 15..1D with DEPTH=8 and no reads -> ev_count=8, overflow=1, head 15, last entry 1C. Then ovf_clr pulse -> overflow=0.
- FIFO full, 2D arrives with rd_en=1 in the same cycle -> ev_count stays 8, overflow stays 0, tail entry is 2D. Asserting reset mid-E0 -> all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_key_event_decoder_pkg.sv
// Shared definitions for the PS/2 set-2 key event decoder: protocol byte values,
// decoder FSM states and the packed key event word.
package ps2_kbd_pkg;

    localparam logic [7:0] PS2_E0     = 8'hE0;
    localparam logic [7:0] PS2_F0     = 8'hF0;
    localparam logic [7:0] PS2_E1     = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    localparam int EVENT_W = 10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GOT_E0   = 3'd1,
        GOT_F0   = 3'd2,
        GOT_E0F0 = 3'd3,
        SKIP_E1  = 3'd4
    } kbd_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    // Keyboard status/response bytes never describe a key and are dropped in IDLE.
    function automatic logic is_status_byte(input logic [7:0] b);
        case (b)
            PS2_BAT_OK, PS2_ACK, PS2_RESEND, PS2_ECHO, PS2_ERR0, PS2_ERR1: is_status_byte = 1'b1;
            default:                                                      is_status_byte = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Byte-input / event-output bundle between the PS/2 receiver, the decoder and
// the firmware-side reader.
interface ps2_key_event_decoder_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          rx_done_tick;
    logic [7:0]    din;
    logic          rd_en;
    logic          ev_valid;
    logic          ev_ext;
    logic          ev_brk;
    logic [7:0]    ev_code;
    logic [CW-1:0] ev_count;
    logic          overflow;
    logic          ovf_clr;
    logic          proto_err;

    modport master (
        output rx_done_tick, din, rd_en, ovf_clr,
        input  ev_valid, ev_ext, ev_brk, ev_code, ev_count, overflow, proto_err
    );

    modport slave (
        input  rx_done_tick, din, rd_en, ovf_clr,
        output ev_valid, ev_ext, ev_brk, ev_code, ev_count, overflow, proto_err
    );

endinterface

// File: rtl/ps2_key_event_decoder_fifo.sv
// First-word-fall-through event queue; the head word is always visible on data_o
// and count is the difference of the wrap-extended write and read pointers.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    wr_ptr_q;
    logic [CW-1:0]    rd_ptr_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == CW'(DEPTH));
    assign empty_o = (count_o == CW'(0));
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees a slot in the same cycle, so a full queue still accepts a push alongside it.
    assign do_push_s = push_i & (~full_o | pop_i);
    assign do_pop_s  = pop_i & ~empty_o;

    // Storage and pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= CW'(0);
            rd_ptr_q <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WIDTH'(0);
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
                wr_ptr_q                <= wr_ptr_q + CW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Assembles PS/2 set-2 scan-code byte sequences (E0/F0/E1 prefixes) into key events
// and queues them for the firmware reader, flagging drops and malformed sequences.
module ps2_key_event_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int PAUSE_TAIL     = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    ps2_key_event_decoder_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(PAUSE_TAIL + 1);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    kbd_state_e    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [SW-1:0] skip_q, skip_d;
    logic          perr_q, perr_d;
    logic          ovf_q, ovf_d;
    logic          push_s;
    key_event_t    push_ev_s;
    key_event_t    head_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic          drop_s;

    // State, timeout, pause-skip and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tmo_q   <= TW'(0);
            skip_q  <= SW'(0);
            perr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            skip_q  <= skip_d;
            perr_q  <= perr_d;
            ovf_q   <= ovf_d;
        end
    end

    // Sequence decoder: a received byte always takes priority over an expiring timeout.
    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        tmo_d     = tmo_q;
        perr_d    = 1'b0;
        push_s    = 1'b0;
        push_ev_s = '{ext: 1'b0, brk: 1'b0, code: 8'h00};

        if (state_q == IDLE) begin
            tmo_d = TW'(0);
        end else if (bus.rx_done_tick) begin
            tmo_d = TW'(0);
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (bus.rx_done_tick) begin
            case (state_q)
                IDLE: begin
                    if (bus.din == PS2_E0) begin
                        state_d = GOT_E0;
                    end else if (bus.din == PS2_F0) begin
                        state_d = GOT_F0;
                    end else if (bus.din == PS2_E1) begin
                        state_d = SKIP_E1;
                        skip_d  = SW'(PAUSE_TAIL);
                    end else if (is_status_byte(bus.din)) begin
                        state_d = IDLE;
                    end else begin
                        push_s    = 1'b1;
                        push_ev_s = '{ext: 1'b0, brk: 1'b0, code: bus.din};
                    end
                end
                GOT_E0: begin
                    if (bus.din == PS2_F0) begin
                        state_d = GOT_E0F0;
                    end else if (bus.din == PS2_E0) begin
                        perr_d = 1'b1;
                    end else if (bus.din == PS2_E1) begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        push_s    = 1'b1;
                        push_ev_s = '{ext: 1'b1, brk: 1'b0, code: bus.din};
                        state_d   = IDLE;
                    end
                end
                GOT_F0: begin
                    if (bus.din == PS2_E0) begin
                        perr_d  = 1'b1;
                        state_d = GOT_E0;
                    end else if (bus.din == PS2_F0) begin
                        perr_d = 1'b1;
                    end else begin
                        push_s    = 1'b1;
                        push_ev_s = '{ext: 1'b0, brk: 1'b1, code: bus.din};
                        state_d   = IDLE;
                    end
                end
                GOT_E0F0: begin
                    if ((bus.din == PS2_E0) || (bus.din == PS2_F0)) begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        push_s    = 1'b1;
                        push_ev_s = '{ext: 1'b1, brk: 1'b1, code: bus.din};
                        state_d   = IDLE;
                    end
                end
                SKIP_E1: begin
                    skip_d = skip_q - SW'(1);
                    if (skip_q == SW'(1)) begin
                        push_s    = 1'b1;
                        push_ev_s = '{ext: 1'b1, brk: 1'b0, code: PS2_E1};
                        state_d   = IDLE;
                    end else begin
                        state_d = SKIP_E1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if ((state_q != IDLE) && (tmo_q == TMO_LAST)) begin
            state_d = IDLE;
            perr_d  = 1'b1;
            tmo_d   = TW'(0);
        end else begin
            state_d = state_q;
        end
    end

    assign drop_s = push_s & fifo_full_s & ~bus.rd_en;

    // Sticky overflow; a drop in the same cycle as a clear leaves it set.
    always_comb begin
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    ps2_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push_s),
        .data_i  (push_ev_s),
        .pop_i   (bus.rd_en),
        .data_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    assign bus.ev_valid  = ~fifo_empty_s;
    assign bus.ev_ext    = head_s.ext;
    assign bus.ev_brk    = head_s.brk;
    assign bus.ev_code   = head_s.code;
    assign bus.ev_count  = fifo_count_s;
    assign bus.overflow  = ovf_q;
    assign bus.proto_err = perr_q;

endmodule
